// File: rtl/product_bcd_display_if.sv
// ---------------------------------------------------------------------------
// product_bcd_display_if
//   Bundles the product handshake, the BCD result and the display drive of
//   product_bcd_display.
//
//   Handshake: a product is transferred on a rising clk edge where
//   prod_valid && prod_ready are both high. prod_ready is high only while
//   the converter is idle. prod_in and prod_valid are ignored while
//   prod_ready is low. bcd_valid pulses for one cycle when bcd_out updates.
//
//   Signals:
//     prod_in    [7:0]  unsigned product from the multiplier datapath
//     prod_valid        prod_in is valid
//     prod_ready        converter idle, a product can be accepted
//     busy              conversion in progress (== !prod_ready)
//     bcd_out    [11:0] hundreds/tens/ones of the last completed conversion
//     bcd_valid         one-cycle pulse when bcd_out updates
//     seg        [6:0]  active-high segments, seg[0]=a .. seg[6]=g
//     dig_sel    [2:0]  one-hot digit enable, bit0 ones .. bit2 hundreds
//
//   Modports: slave = converter side, master = producer/observer side.
// ---------------------------------------------------------------------------
interface product_bcd_display_if;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic        busy;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;

    modport slave (
        input  prod_in, prod_valid,
        output prod_ready, busy, bcd_out, bcd_valid, seg, dig_sel
    );

    modport master (
        output prod_in, prod_valid,
        input  prod_ready, busy, bcd_out, bcd_valid, seg, dig_sel
    );
endinterface

// File: rtl/product_bcd_display.sv
// ---------------------------------------------------------------------------
// product_bcd_display
//   Accepts an 8-bit product over valid/ready, converts it to three BCD
//   digits with a sequential double-dabble engine (one iteration per clock),
//   and drives a time-multiplexed 3-digit 7-segment display from the last
//   completed result, with optional leading-zero blanking.
//
//   Ports:
//     clk          system clock, all state on the rising edge
//     rst_n        asynchronous active-low reset
//     prod_if      product_bcd_display_if.slave (handshake, result, display)
//     o_dbg_state  current FSM state (0 = IDLE, 1 = CONVERT)
//
//   Parameters:
//     SCAN_DIV       clock cycles each digit stays selected (>= 2)
//     BLANK_LEADING  1 = blank leading-zero hundreds/tens digits
//
//   Timing: handshake at edge E0, result and bcd_valid visible after E8,
//   earliest next acceptance at E9.
// ---------------------------------------------------------------------------
module product_bcd_display #(
    parameter int SCAN_DIV      = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    product_bcd_display_if.slave        prod_if,
    output logic                        o_dbg_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

    state_t       r_state;
    state_t       w_next_state;
    logic         w_accept;
    logic         w_last_iter;

    logic [7:0]   r_bin;
    logic [11:0]  r_scratch;
    logic [3:0]   r_cnt;
    logic [11:0]  r_bcd_out;
    logic         r_bcd_valid;

    logic [11:0]  w_adj;
    logic [11:0]  w_next_scratch;
    logic [7:0]   w_next_bin;

    logic [PW-1:0] r_prescale;
    logic [2:0]    r_dig_sel;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic [6:0]    w_seg_code;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last_iter  = 1'b0;
        case (r_state)
            IDLE: begin
                if (prod_if.prod_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CONVERT;
                end
            end
            CONVERT: begin
                // Counter still at 1 means this edge performs the 8th iteration.
                if (r_cnt == 4'd1) begin
                    w_last_iter  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    // Add-3 correction on every nibble >= 5, then shift {scratch, bin} left.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
            end
        end
        w_next_scratch = {w_adj[10:0], r_bin[7]};
        w_next_bin     = {r_bin[6:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin       <= 8'h00;
            r_scratch   <= 12'h000;
            r_cnt       <= 4'd0;
            r_bcd_out   <= 12'h000;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            if (w_accept) begin
                r_bin     <= prod_if.prod_in;
                r_scratch <= 12'h000;
                r_cnt     <= 4'd8;
            end else if (r_state == CONVERT) begin
                r_scratch <= w_next_scratch;
                r_bin     <= w_next_bin;
                r_cnt     <= r_cnt - 4'd1;
                if (w_last_iter) begin
                    // Result is committed in one go so bcd_out never shows a
                    // partially converted value.
                    r_bcd_out   <= w_next_scratch;
                    r_bcd_valid <= 1'b1;
                end
            end
        end
    end

    // ---------------- display scan ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_dig_sel  <= 3'b001;
        end else begin
            if (r_prescale == PS_MAX) begin
                r_prescale <= '0;
                r_dig_sel  <= {r_dig_sel[1:0], r_dig_sel[2]};
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end
        end
    end

    // Segment drive follows bcd_out combinationally so a new result shows
    // up on the currently selected digit without waiting for the next scan.
    always_comb begin
        w_nibble = r_bcd_out[3:0];
        w_blank  = 1'b0;
        case (r_dig_sel)
            3'b010: begin
                w_nibble = r_bcd_out[7:4];
                w_blank  = BLANK_LEADING && (r_bcd_out[11:8] == 4'd0)
                                         && (r_bcd_out[7:4] == 4'd0);
            end
            3'b100: begin
                w_nibble = r_bcd_out[11:8];
                w_blank  = BLANK_LEADING && (r_bcd_out[11:8] == 4'd0);
            end
            default: begin
                w_nibble = r_bcd_out[3:0];
                w_blank  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_seg_code = 7'h00;
        case (w_nibble)
            4'd0:    w_seg_code = 7'h3F;
            4'd1:    w_seg_code = 7'h06;
            4'd2:    w_seg_code = 7'h5B;
            4'd3:    w_seg_code = 7'h4F;
            4'd4:    w_seg_code = 7'h66;
            4'd5:    w_seg_code = 7'h6D;
            4'd6:    w_seg_code = 7'h7D;
            4'd7:    w_seg_code = 7'h07;
            4'd8:    w_seg_code = 7'h7F;
            4'd9:    w_seg_code = 7'h6F;
            default: w_seg_code = 7'h00;
        endcase
    end

    // ---------------- outputs ----------------
    assign prod_if.prod_ready = (r_state == IDLE);
    assign prod_if.busy       = (r_state != IDLE);
    assign prod_if.bcd_out    = r_bcd_out;
    assign prod_if.bcd_valid  = r_bcd_valid;
    assign prod_if.dig_sel    = r_dig_sel;
    assign prod_if.seg        = w_blank ? 7'h00 : w_seg_code;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_product_bcd_display.sv
module tb_product_bcd_display;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_bcd_display_if if_a ();
  product_bcd_display_if if_b ();
  logic dbg_a;
  logic dbg_b;

  // dut_a blanks leading zeros, dut_b always shows three digits.
  product_bcd_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod_if(if_a.slave), .o_dbg_state(dbg_a)
  );
  product_bcd_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod_if(if_b.slave), .o_dbg_state(dbg_b)
  );

  int n_pass = 0;
  int n_total = 0;
  int edge_cnt = 0;

  logic [6:0] seg_tab [10];

  typedef struct {
    logic [7:0]  prod;
    logic [11:0] bcd;
  } vec_t;
  vec_t vecs [7];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic drive(input logic [7:0] v, input logic valid);
    if_a.prod_in = v;
    if_b.prod_in = v;
    if_a.prod_valid = valid;
    if_b.prod_valid = valid;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx, input bit blank_en);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = b[11:8];
    t = b[7:4];
    o = b[3:0];
    if (idx == 0) return seg_tab[o];
    if (idx == 1) return (blank_en && h == 4'd0 && t == 4'd0) ? 7'h00 : seg_tab[t];
    return (blank_en && h == 4'd0) ? 7'h00 : seg_tab[h];
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_bcd_out"}, if_a.bcd_out, 12'h000);
    chk({tag, "_bcd_valid"}, 12'(if_a.bcd_valid), 12'h0);
    chk({tag, "_ready"}, 12'(if_a.prod_ready), 12'h1);
    chk({tag, "_busy"}, 12'(if_a.busy), 12'h0);
    chk({tag, "_dig_sel"}, 12'(if_a.dig_sel), 12'h001);
    chk({tag, "_seg"}, 12'(if_a.seg), 12'h03F);
    chk({tag, "_state"}, 12'(dbg_a), 12'h0);
  endtask

  // One full handshake + conversion, checking the cycle-by-cycle timeline.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    int waited;
    waited = 0;
    while (!if_a.prod_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("ready_before_accept", 12'(if_a.prod_ready), 12'h1);
    drive(v, 1'b1);
    tick();                      // E0
    drive(~v, 1'b0);             // input change after capture must not matter
    chk("ready_after_E0", 12'(if_a.prod_ready), 12'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        chk("ready_low_convert", 12'(if_a.prod_ready), 12'h0);
        chk("busy_high_convert", 12'(if_a.busy), 12'h1);
        chk("no_early_valid", 12'(if_a.bcd_valid), 12'h0);
      end else begin
        chk("valid_at_E8", 12'(if_a.bcd_valid), 12'h1);
        chk("bcd_out_a", if_a.bcd_out, exp);
        chk("bcd_out_b", if_b.bcd_out, exp);
        chk("ready_after_E8", 12'(if_a.prod_ready), 12'h1);
        chk("busy_after_E8", 12'(if_a.busy), 12'h0);
      end
    end
    tick();
    chk("valid_single_pulse", 12'(if_a.bcd_valid), 12'h0);
    chk("bcd_out_holds", if_a.bcd_out, exp);
  endtask

  task automatic check_display(input logic [11:0] b, input int cycles);
    int idx;
    for (int c = 0; c < cycles; c++) begin
      idx = (edge_cnt / 4) % 3;
      chk("dig_sel", 12'(if_a.dig_sel), 12'(1 << idx));
      chk("seg_blank", 12'(if_a.seg), 12'(exp_seg(b, idx, 1'b1)));
      chk("seg_noblank", 12'(if_b.seg), 12'(exp_seg(b, idx, 1'b0)));
      tick();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int k;
    int p;
    int first_k;
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    vecs[0] = '{prod: 8'd225, bcd: 12'h225};
    vecs[1] = '{prod: 8'd0,   bcd: 12'h000};
    vecs[2] = '{prod: 8'd9,   bcd: 12'h009};
    vecs[3] = '{prod: 8'd10,  bcd: 12'h010};
    vecs[4] = '{prod: 8'd99,  bcd: 12'h099};
    vecs[5] = '{prod: 8'd100, bcd: 12'h100};
    vecs[6] = '{prod: 8'd255, bcd: 12'h255};

    // Reset
    drive(8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    edge_cnt = 0;

    // Table-driven conversions
    for (int i = 0; i < 7; i++) begin
      convert(vecs[i].prod, vecs[i].bcd);
    end

    // prod_valid held high, prod_in changing every cycle: accepts every 9 edges
    for (k = 0; k < 27; k++) begin
      p = (k * 53 + 17) % 256;
      drive(8'(p), 1'b1);
      tick();
      if (k % 9 == 8) begin
        first_k = k - 8;
        chk("held_valid_pulse", 12'(if_a.bcd_valid), 12'h1);
        chk("held_bcd_out", if_a.bcd_out, to_bcd((first_k * 53 + 17) % 256));
        chk("held_ready", 12'(if_a.prod_ready), 12'h1);
      end else begin
        chk("held_no_pulse", 12'(if_a.bcd_valid), 12'h0);
        chk("held_ready_low", 12'(if_a.prod_ready), 12'h0);
      end
    end
    drive(8'h00, 1'b0);
    tick();

    // Display of 7: blanked vs non-blanked leading digits
    convert(8'd7, 12'h007);
    chk("seg7_tab_ones", 12'(exp_seg(12'h007, 0, 1'b1)), 12'h007);
    check_display(12'h007, 24);

    // Display of 105: tens zero shown because hundreds is non-zero
    convert(8'd105, 12'h105);
    check_display(12'h105, 24);

    // Reset in the middle of converting 200
    drive(8'd200, 1'b1);
    tick();                      // E0
    drive(8'd200, 1'b0);
    repeat (4) tick();
    chk("mid_state_convert", 12'(dbg_a), 12'h1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    edge_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_pulse_after_reset", 12'(if_a.bcd_valid), 12'h0);
      chk("bcd_out_stays_zero", if_a.bcd_out, 12'h000);
    end
    convert(8'd48, 12'h048);
    check_display(12'h048, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
